// File: rtl/hazard_pkg.sv
// Shared definitions for the decode hazard unit: opcode nibbles, PC-select
// encodings, the scoreboard entry layout and the source-usage decode.
package hazard_pkg;

  localparam logic [3:0] OP_ALU  = 4'b0000;
  localparam logic [3:0] OP_CMP  = 4'b0010;
  localparam logic [3:0] OP_BR   = 4'b0110;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_ALUI = 4'b1000;
  localparam logic [3:0] OP_CMPI = 4'b1010;
  localparam logic [3:0] OP_LW   = 4'b1001;
  localparam logic [3:0] OP_JAL  = 4'b1011;
  localparam logic [3:0] OP_SPC  = 4'b1111;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JAL    = 2'b10,
    PC_BUBBLE = 2'b11
  } pc_sel_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] addr;
  } sb_entry_t;

  typedef struct packed {
    logic s1;
    logic s2;
  } src_use_t;

  // Which source operands the instruction in decode actually reads.
  function automatic src_use_t decode_use(input logic [3:0] op);
    src_use_t u;
    u = '0;
    case (op)
      OP_ALU, OP_CMP, OP_BR, OP_SW: begin
        u.s1 = 1'b1;
        u.s2 = 1'b1;
      end
      OP_ALUI, OP_CMPI, OP_LW, OP_JAL: u.s1 = 1'b1;
      OP_SPC:                          u.s2 = 1'b1;
      default:                         u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift register of in-flight register writes. Each entry lives for exactly
// DEPTH cycles, matching the distance from decode to register-file write.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wrtEn,
  input  logic [3:0]       wrtAddr,
  input  logic [3:0]       s1Addr,
  input  logic [3:0]       s2Addr,
  output logic [DEPTH-1:0] s1Match,
  output logic [DEPTH-1:0] s2Match
);

  sb_entry_t entries [DEPTH];

  // Decode's write intent enters at entry 0 and ages one slot per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) entries[k] <= '0;
    end else begin
      entries[0] <= '{valid: wrtEn, addr: wrtAddr};
      for (int k = 1; k < DEPTH; k++) entries[k] <= entries[k-1];
    end
  end

  // Per-entry address match against both source fields; R0 is not special.
  always_comb begin
    s1Match = '0;
    s2Match = '0;
    for (int k = 0; k < DEPTH; k++) begin
      s1Match[k] = entries[k].valid && (entries[k].addr == s1Addr);
      s2Match[k] = entries[k].valid && (entries[k].addr == s2Addr);
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Decode-side hazard unit: stalls on read-after-write hazards against the
// scoreboard and bubbles wrong-path instructions after a redirect.
// FLUSH_CYCLES must lie in 1..7 to fit the 3-bit flush counter.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int WB_DEPTH     = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  opHi,
  input  logic [3:0]  s1RegAddr,
  input  logic [3:0]  s2RegAddr,
  input  logic [3:0]  dRegAddr,
  input  logic        regFileWrtEn,
  input  logic [1:0]  pcSel,
  output logic        bubble,
  output logic        pcStall,
  output logic [15:0] stallCount
);

  logic [WB_DEPTH-1:0] s1Match;
  logic [WB_DEPTH-1:0] s2Match;
  logic [2:0]          flushCnt;
  logic                flushing;
  logic                hazard;
  src_use_t            srcUse;

  hazard_scoreboard #(.DEPTH(WB_DEPTH)) u_scoreboard (
    .clk     (clk),
    .reset_n (reset_n),
    .wrtEn   (regFileWrtEn),
    .wrtAddr (dRegAddr),
    .s1Addr  (s1RegAddr),
    .s2Addr  (s2RegAddr),
    .s1Match (s1Match),
    .s2Match (s2Match)
  );

  // Hazard and bubble are purely combinational; a pending flush masks stalls.
  always_comb begin
    srcUse   = decode_use(opHi);
    flushing = (flushCnt != 3'd0);
    hazard   = !flushing && ((srcUse.s1 && (|s1Match)) || (srcUse.s2 && (|s2Match)));
    bubble   = hazard || flushing;
    pcStall  = hazard;
  end

  // pcSel only reaches this register, so bubble never loops back through it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flushCnt <= 3'd0;
    end else if (pcSel == PC_BRANCH || pcSel == PC_JAL) begin
      flushCnt <= 3'(FLUSH_CYCLES);
    end else if (flushCnt != 3'd0) begin
      flushCnt <= flushCnt - 3'd1;
    end
  end

  // Saturating tally of cycles lost to data hazards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stallCount <= 16'd0;
    end else if (hazard && stallCount != 16'hFFFF) begin
      stallCount <= stallCount + 16'd1;
    end
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Generates the `bubble` and PC-hold signals consumed by the decode controller. It sits beside decode and observes the controller's decoded fields. It tracks in-flight register writes in a scoreboard and stalls decode on read-after-write hazards. After a taken branch or JAL it squashes wrong-path instructions for a fixed number of cycles.

## Interface
- `WB_DEPTH`, 3: pipeline stages between decode and register-file write; the number of scoreboard entries.
- `FLUSH_CYCLES`, 2: wrong-path instructions squashed after a redirect; must be 1..7.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `opHi`  in  4  `inst[31:28]` of the instruction in decode.
- `s1RegAddr`, `s2RegAddr`  in  4 each  source addresses from the controller.
- `dRegAddr`  in  4  destination address from the controller.
- `regFileWrtEn`  in  1  controller write enable; already masked by `bubble`.
- `pcSel`  in  2  controller PC select: 00 = +4, 01 = branch, 10 = JAL, 11 = bubble.
- `bubble`  out  1  to controller; kills the decode instruction's side effects.
- `pcStall`  out  1  to fetch; holds the PC and the decode latch this cycle.
- `stallCount`  out  16  saturating count of data-hazard stall cycles.

## Operation
- Source usage is decoded from `opHi`:
  - 0000, 0010, 0110, 0101: read s1 and s2.
  - 1000, 1010, 1001, 1011: read s1 only.
  - 1111: reads s2 only.
  - Any other opcode reads nothing.
- No register is hardwired. R0 compares like any other register.
- Scoreboard: a shift register of `WB_DEPTH` entries, each {valid, addr[3:0]}.
  - Every cycle entry 0 loads {`regFileWrtEn`, `dRegAddr`}.
  - Entry k loads entry k-1. The last entry drops off.
  - A bubbled instruction enters as valid=0, because the controller has already masked its write enable.
- `hazard` = (flushCnt == 0) AND (a used source equals the addr of any valid entry).
- `bubble` = `hazard` OR (flushCnt != 0).
- `pcStall` = `hazard`.
- Flush counter flushCnt, 3 bits:
  - Loads `FLUSH_CYCLES` when `pcSel` is 01 or 10.
  - Otherwise decrements when nonzero.
  - `pcSel` = 11 never loads it.
- Wrong-path instructions are not stalled; they are only bubbled.
- `stallCount` increments on each cycle with `hazard` = 1 and saturates at 0xFFFF.

## Timing
- Reset, asynchronous: all scoreboard entries invalid with addr 0; flushCnt = 0; `stallCount` = 0. Hence `bubble` = 0 and `pcStall` = 0 immediately.
- `bubble` and `pcStall` are combinational from the decode fields and registered state in the same cycle.
- `pcSel` feeds flip-flops only, which breaks the bubble → pcSel → bubble loop.
- The register file does not bypass. An entry blocks reads for exactly `WB_DEPTH` cycles after its decode cycle.
- A dependent instruction issued directly behind its producer stalls `WB_DEPTH` cycles, then proceeds.
- Redirect at cycle t: `bubble` = 1 for cycles t+1 .. t+`FLUSH_CYCLES`, and `pcStall` = 0 throughout.
- A hazard and a nonzero flushCnt in the same cycle: flush wins, no stall, and `stallCount` is unchanged.
- Reset asserted mid-stall or mid-flush: outputs clear asynchronously. The first instruction after release sees an empty scoreboard.

## Structure
- Shared package `hazard_pkg`:
  - Opcode-nibble constants (OP_ALU, OP_ALUI, OP_CMP, OP_CMPI, OP_BR, OP_LW, OP_SW, OP_JAL, OP_SPC).
  - pcSel encodings.
  - Scoreboard entry typedef.
- One sub-module, `hazard_scoreboard`: the parameterised shift register plus a match vector output. The top level holds usage decode, the flush counter and the stall counter.

## Test plan
- **RAW stall:** decode ADD r3 (op 0000, d=3, regFileWrtEn=1), then ADD using s1=3 → `bubble` = `pcStall` = 1 for 3 cycles, released on the 4th; `stallCount` = 3.
- **Unused source:** ADDI (op 1000) with s2RegAddr = 3 while r3 is in flight → no stall. BEQ (op 0110) with s2 = 3 → stalls.
- **Branch flush:** `pcSel` = 01 at cycle 10 → `bubble` = 1 at cycles 11–12, `pcStall` = 0, and a dependent wrong-path instruction does not increment `stallCount`.
- **Special register:** op 1111 with s2RegAddr = 5 while r5 is in flight → stall. Op 1111 with sub-op 2 and d=7 → r7 is scoreboarded.
- **Saturation:** force 70000 hazard cycles → `stallCount` holds 0xFFFF.
- **Reset mid-operation:** pull `reset_n` low during a stall → `bubble`, `pcStall` and `stallCount` go to 0 before the next clock edge.
